// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory bus bundle for the load/store unit.
// The LSU connects through the slave modport; the core/memory side uses master.
interface load_store_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                    i_req_valid;
   logic                    i_req_write;
   logic [2:0]              i_funct3;
   logic [ADDR_WIDTH-1:0]   i_addr;
   logic [DATA_WIDTH-1:0]   i_wdata;
   logic                    o_req_ready;
   logic                    o_stall;
   logic                    o_rsp_valid;
   logic                    o_rsp_err;
   logic [DATA_WIDTH-1:0]   o_rdata;
   logic                    o_mem_req;
   logic                    o_mem_we;
   logic [DATA_WIDTH/8-1:0] o_mem_be;
   logic [ADDR_WIDTH-1:0]   o_mem_addr;
   logic [DATA_WIDTH-1:0]   o_mem_wdata;
   logic                    i_mem_ack;
   logic [DATA_WIDTH-1:0]   i_mem_rdata;

   modport slave (
      input  i_req_valid, i_req_write, i_funct3, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
      output o_req_ready, o_stall, o_rsp_valid, o_rsp_err, o_rdata,
             o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata
   );

   modport master (
      output i_req_valid, i_req_write, i_funct3, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
      input  o_req_ready, o_stall, o_rsp_valid, o_rsp_err, o_rdata,
             o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: sub-word lane steering, sign/zero extension,
// request hold until ack, pipeline stall, misalignment and timeout errors.
//
//   state  | meaning
//   IDLE   | ready for a new access
//   BUSY   | memory request outstanding, waiting for ack or timeout
//   RESP   | one-cycle response pulse
module load_store_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 15
) (
   input logic              clk,
   input logic              rst,
   load_store_unit_if.slave bus
);
   localparam int NB   = DATA_WIDTH / 8;
   localparam int OFFW = $clog2(NB);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [OFFW-1:0]       off_q, off_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [NB-1:0]         mem_be_q, mem_be_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  misaligned;
   logic [7:0]            be_base;
   logic [15:0]           be_wide;
   logic [OFFW-1:0]       req_off;
   logic [DATA_WIDTH-1:0] wdata_rep;
   logic [DATA_WIDTH-1:0] lane;
   logic [DATA_WIDTH-1:0] load_ext;
   logic                  sign;
   logic [3:0]            cnt_inc;

   assign req_off = bus.i_addr[OFFW-1:0];
   assign cnt_inc = cnt_q + 4'd1;

   // Illegal encodings (111, and 011 on a 32-bit bus) are reported like misalignment.
   always_comb begin
      misaligned = 1'b0;
      case (bus.i_funct3)
         3'b001, 3'b101: misaligned = bus.i_addr[0];
         3'b010, 3'b110: misaligned = |bus.i_addr[1:0];
         3'b011:         misaligned = (DATA_WIDTH != 64) || (|bus.i_addr[2:0]);
         3'b111:         misaligned = 1'b1;
         default:        misaligned = 1'b0;
      endcase
   end

   always_comb begin
      be_base   = 8'hFF;
      wdata_rep = bus.i_wdata;
      case (bus.i_funct3[1:0])
         2'b00: begin
            be_base   = 8'h01;
            wdata_rep = {NB{bus.i_wdata[7:0]}};
         end
         2'b01: begin
            be_base   = 8'h03;
            wdata_rep = {(NB/2){bus.i_wdata[15:0]}};
         end
         2'b10: begin
            be_base   = 8'h0F;
            wdata_rep = {(NB/4){bus.i_wdata[31:0]}};
         end
         default: begin
            be_base   = 8'hFF;
            wdata_rep = bus.i_wdata;
         end
      endcase
      be_wide = {8'h00, be_base} << req_off;
   end

   always_comb begin
      lane     = bus.i_mem_rdata >> {off_q, 3'b000};
      sign     = ~funct3_q[2];
      load_ext = lane;
      case (funct3_q[1:0])
         2'b00: for (int i = 8; i < DATA_WIDTH; i++) load_ext[i] = sign & lane[7];
         2'b01: for (int i = 16; i < DATA_WIDTH; i++) load_ext[i] = sign & lane[15];
         2'b10: for (int i = 32; i < DATA_WIDTH; i++) load_ext[i] = sign & lane[31];
         default: load_ext = lane;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rdata_d     = '0;
      case (state_q)
         S_IDLE: begin
            if (bus.i_req_valid) begin
               if (misaligned) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d     = S_BUSY;
                  cnt_d       = 4'd0;
                  funct3_d    = bus.i_funct3;
                  off_d       = req_off;
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.i_req_write;
                  mem_be_d    = be_wide[NB-1:0];
                  mem_addr_d  = {bus.i_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                  mem_wdata_d = wdata_rep;
               end
            end
         end
         S_BUSY: begin
            // Ack takes priority over the timeout expiring in the same cycle.
            if (bus.i_mem_ack) begin
               state_d     = S_RESP;
               mem_req_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rdata_d     = mem_we_q ? '0 : load_ext;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == 4'(TIMEOUT)) begin
                  state_d     = S_RESP;
                  mem_req_d   = 1'b0;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         funct3_q    <= 3'd0;
         off_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rdata_q     <= rdata_d;
      end
   end

   assign bus.o_req_ready = (state_q == S_IDLE);
   assign bus.o_stall     = (bus.i_req_valid & (state_q != S_IDLE)) | (state_q == S_BUSY);
   assign bus.o_rsp_valid = rsp_valid_q;
   assign bus.o_rsp_err   = rsp_err_q;
   assign bus.o_rdata     = rdata_q;
   assign bus.o_mem_req   = mem_req_q;
   assign bus.o_mem_we    = mem_we_q;
   assign bus.o_mem_be    = mem_be_q;
   assign bus.o_mem_addr  = mem_addr_q;
   assign bus.o_mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit on a 32-bit bus with TIMEOUT=15.
module tb_load_store_unit;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   load_store_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   localparam int NLD = 6;
   localparam logic [2:0]  LD_F3  [NLD] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110};
   localparam logic [31:0] LD_AD  [NLD] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002,
                                            32'h0000_2002, 32'h0000_0004, 32'h0000_0008};
   localparam logic [31:0] LD_RD  [NLD] = '{32'h0000_007F, 32'h0000_8000, 32'hBEEF_1234,
                                            32'hBEEF_1234, 32'h8765_4321, 32'h8765_4321};
   localparam logic [3:0]  LD_BE  [NLD] = '{4'b0001, 4'b0010, 4'b1100, 4'b1100, 4'b1111, 4'b1111};
   localparam logic [31:0] LD_EXP [NLD] = '{32'h0000_007F, 32'h0000_0080, 32'hFFFF_BEEF,
                                            32'h0000_BEEF, 32'h8765_4321, 32'h8765_4321};

   localparam int NST = 3;
   localparam logic [2:0]  ST_F3 [NST] = '{3'b000, 3'b001, 3'b010};
   localparam logic [31:0] ST_AD [NST] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0004};
   localparam logic [31:0] ST_WD [NST] = '{32'h1234_56A5, 32'h0000_BEEF, 32'hDEAD_BEEF};
   localparam logic [31:0] ST_EW [NST] = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'hDEAD_BEEF};
   localparam logic [3:0]  ST_BE [NST] = '{4'b0010, 4'b1100, 4'b1111};

   localparam int NMA = 6;
   localparam logic        MA_WR [NMA] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [2:0]  MA_F3 [NMA] = '{3'b010, 3'b001, 3'b101, 3'b010, 3'b111, 3'b011};
   localparam logic [31:0] MA_AD [NMA] = '{32'h0000_0006, 32'h0000_0001, 32'h0000_0003,
                                           32'h0000_0002, 32'h0000_0000, 32'h0000_0000};

   task automatic idle_inputs();
      bus.i_req_valid = 1'b0;
      bus.i_req_write = 1'b0;
      bus.i_funct3    = 3'b000;
      bus.i_addr      = '0;
      bus.i_wdata     = '0;
      bus.i_mem_ack   = 1'b0;
      bus.i_mem_rdata = '0;
   endtask

   task automatic drive_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd);
      bus.i_req_valid = 1'b1;
      bus.i_req_write = wr;
      bus.i_funct3    = f3;
      bus.i_addr      = addr;
      bus.i_wdata     = wd;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      #2;
      checks++; if (bus.o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.o_req_ready); end
      checks++; if (bus.o_mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.o_mem_req); end
      checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.o_rsp_valid); end
      checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.o_stall); end
      checks++; if (bus.o_mem_be !== 4'h0 || bus.o_rdata !== 32'h0) begin errors++; $display("FAIL reset_regs: be=%h rdata=%h want 0", bus.o_mem_be, bus.o_rdata); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_lb_wait();
      @(negedge clk);
      drive_req(1'b0, 3'b000, 32'h0000_1003, 32'h0);
      @(negedge clk);
      checks++; if (bus.o_mem_req !== 1'b1 || bus.o_stall !== 1'b1) begin errors++; $display("FAIL lb_req: req=%b stall=%b want 1 1", bus.o_mem_req, bus.o_stall); end
      checks++; if (bus.o_mem_be !== 4'b1000 || bus.o_mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_be_addr: be=%b addr=%h want 1000 00001000", bus.o_mem_be, bus.o_mem_addr); end
      drive_req(1'b1, 3'b010, 32'h0000_5550, 32'hFFFF_FFFF);
      @(negedge clk);
      checks++; if (bus.o_mem_addr !== 32'h0000_1000 || bus.o_mem_we !== 1'b0 || bus.o_mem_be !== 4'b1000) begin errors++; $display("FAIL lb_hold: addr=%h we=%b be=%b want 00001000 0 1000", bus.o_mem_addr, bus.o_mem_we, bus.o_mem_be); end
      idle_inputs();
      bus.i_mem_ack   = 1'b1;
      bus.i_mem_rdata = 32'h80FF_0000;
      @(negedge clk);
      idle_inputs();
      checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_err !== 1'b0) begin errors++; $display("FAIL lb_rsp: valid=%b err=%b want 1 0", bus.o_rsp_valid, bus.o_rsp_err); end
      checks++; if (bus.o_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h want ffffff80", bus.o_rdata); end
      checks++; if (bus.o_mem_req !== 1'b0) begin errors++; $display("FAIL lb_req_drop: got %b want 0", bus.o_mem_req); end
      @(negedge clk);
      checks++; if (bus.o_rsp_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin errors++; $display("FAIL lb_pulse: valid=%b ready=%b want 0 1", bus.o_rsp_valid, bus.o_req_ready); end
   endtask

   task automatic test_load_vectors();
      for (int i = 0; i < NLD; i++) begin
         @(negedge clk);
         drive_req(1'b0, LD_F3[i], LD_AD[i], 32'h0);
         @(negedge clk);
         idle_inputs();
         checks++; if (bus.o_mem_req !== 1'b1 || bus.o_mem_be !== LD_BE[i]) begin errors++; $display("FAIL ld%0d_be: req=%b be=%b want 1 %b", i, bus.o_mem_req, bus.o_mem_be, LD_BE[i]); end
         checks++; if (bus.o_mem_addr !== {LD_AD[i][31:2], 2'b00}) begin errors++; $display("FAIL ld%0d_addr: got %h want %h", i, bus.o_mem_addr, {LD_AD[i][31:2], 2'b00}); end
         bus.i_mem_ack   = 1'b1;
         bus.i_mem_rdata = LD_RD[i];
         @(negedge clk);
         idle_inputs();
         checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_err !== 1'b0 || bus.o_rdata !== LD_EXP[i]) begin errors++; $display("FAIL ld%0d_rsp: valid=%b err=%b rdata=%h want 1 0 %h", i, bus.o_rsp_valid, bus.o_rsp_err, bus.o_rdata, LD_EXP[i]); end
      end
      @(negedge clk);
   endtask

   task automatic test_stores();
      for (int i = 0; i < NST; i++) begin
         @(negedge clk);
         drive_req(1'b1, ST_F3[i], ST_AD[i], ST_WD[i]);
         @(negedge clk);
         idle_inputs();
         checks++; if (bus.o_mem_we !== 1'b1 || bus.o_mem_be !== ST_BE[i] || bus.o_mem_wdata !== ST_EW[i]) begin errors++; $display("FAIL st%0d_bus: we=%b be=%b wdata=%h want 1 %b %h", i, bus.o_mem_we, bus.o_mem_be, bus.o_mem_wdata, ST_BE[i], ST_EW[i]); end
         checks++; if (bus.o_stall !== 1'b1) begin errors++; $display("FAIL st%0d_stall1: got %b want 1", i, bus.o_stall); end
         @(negedge clk);
         checks++; if (bus.o_stall !== 1'b1 || bus.o_mem_req !== 1'b1 || bus.o_mem_wdata !== ST_EW[i]) begin errors++; $display("FAIL st%0d_wait: stall=%b req=%b wdata=%h want 1 1 %h", i, bus.o_stall, bus.o_mem_req, bus.o_mem_wdata, ST_EW[i]); end
         bus.i_mem_ack   = 1'b1;
         bus.i_mem_rdata = 32'hFFFF_FFFF;
         @(negedge clk);
         idle_inputs();
         checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_err !== 1'b0 || bus.o_rdata !== 32'h0 || bus.o_stall !== 1'b0) begin errors++; $display("FAIL st%0d_rsp: valid=%b err=%b rdata=%h stall=%b want 1 0 0 0", i, bus.o_rsp_valid, bus.o_rsp_err, bus.o_rdata, bus.o_stall); end
      end
      @(negedge clk);
   endtask

   task automatic test_misaligned();
      for (int i = 0; i < NMA; i++) begin
         @(negedge clk);
         drive_req(MA_WR[i], MA_F3[i], MA_AD[i], 32'h1234_5678);
         @(negedge clk);
         idle_inputs();
         checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_err !== 1'b1) begin errors++; $display("FAIL ma%0d_rsp: valid=%b err=%b want 1 1", i, bus.o_rsp_valid, bus.o_rsp_err); end
         checks++; if (bus.o_mem_req !== 1'b0 || bus.o_rdata !== 32'h0) begin errors++; $display("FAIL ma%0d_noreq: req=%b rdata=%h want 0 0", i, bus.o_mem_req, bus.o_rdata); end
         @(negedge clk);
         checks++; if (bus.o_mem_req !== 1'b0 || bus.o_req_ready !== 1'b1 || bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL ma%0d_idle: req=%b ready=%b valid=%b want 0 1 0", i, bus.o_mem_req, bus.o_req_ready, bus.o_rsp_valid); end
      end
   endtask

   task automatic test_timeout();
      int req_cycles = 0;
      int guard = 0;
      logic got = 1'b0;
      @(negedge clk);
      drive_req(1'b0, 3'b010, 32'h0000_0010, 32'h0);
      @(negedge clk);
      idle_inputs();
      while (!got && guard < 40) begin
         if (bus.o_rsp_valid === 1'b1) got = 1'b1;
         else begin
            if (bus.o_mem_req === 1'b1) req_cycles++;
            guard++;
            @(negedge clk);
         end
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL to_rsp_seen: got %b want 1 within 40 cycles", got); end
      checks++; if (req_cycles != TO) begin errors++; $display("FAIL to_req_cycles: got %0d want %0d", req_cycles, TO); end
      checks++; if (bus.o_rsp_err !== 1'b1 || bus.o_rdata !== 32'h0 || bus.o_mem_req !== 1'b0) begin errors++; $display("FAIL to_rsp: err=%b rdata=%h req=%b want 1 0 0", bus.o_rsp_err, bus.o_rdata, bus.o_mem_req); end
      @(negedge clk);
   endtask

   task automatic test_ack_at_timeout();
      @(negedge clk);
      drive_req(1'b0, 3'b010, 32'h0000_0020, 32'h0);
      @(negedge clk);
      idle_inputs();
      repeat (TO - 1) @(negedge clk);
      checks++; if (bus.o_mem_req !== 1'b1 || bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL at_last_wait: req=%b valid=%b want 1 0", bus.o_mem_req, bus.o_rsp_valid); end
      bus.i_mem_ack   = 1'b1;
      bus.i_mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      idle_inputs();
      checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_err !== 1'b0 || bus.o_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL at_rsp: valid=%b err=%b rdata=%h want 1 0 cafef00d", bus.o_rsp_valid, bus.o_rsp_err, bus.o_rdata); end
      @(negedge clk);
   endtask

   task automatic test_stray_ack();
      @(negedge clk);
      bus.i_mem_ack   = 1'b1;
      bus.i_mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      idle_inputs();
      checks++; if (bus.o_rsp_valid !== 1'b0 || bus.o_mem_req !== 1'b0 || bus.o_req_ready !== 1'b1) begin errors++; $display("FAIL stray_ack: valid=%b req=%b ready=%b want 0 0 1", bus.o_rsp_valid, bus.o_mem_req, bus.o_req_ready); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      drive_req(1'b0, 3'b010, 32'h0000_0040, 32'h0);
      @(negedge clk);
      idle_inputs();
      bus.i_mem_ack   = 1'b1;
      bus.i_mem_rdata = 32'h0102_0304;
      @(negedge clk);
      idle_inputs();
      drive_req(1'b0, 3'b010, 32'h0000_0044, 32'h0);
      #1;
      checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_stall !== 1'b1 || bus.o_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_resp: valid=%b stall=%b ready=%b want 1 1 0", bus.o_rsp_valid, bus.o_stall, bus.o_req_ready); end
      @(negedge clk);
      checks++; if (bus.o_req_ready !== 1'b1 || bus.o_stall !== 1'b0 || bus.o_mem_req !== 1'b0) begin errors++; $display("FAIL b2b_idle: ready=%b stall=%b req=%b want 1 0 0", bus.o_req_ready, bus.o_stall, bus.o_mem_req); end
      @(negedge clk);
      idle_inputs();
      checks++; if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 32'h0000_0044) begin errors++; $display("FAIL b2b_second: req=%b addr=%h want 1 00000044", bus.o_mem_req, bus.o_mem_addr); end
      bus.i_mem_ack   = 1'b1;
      bus.i_mem_rdata = 32'h0506_0708;
      @(negedge clk);
      idle_inputs();
      checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rdata !== 32'h0506_0708) begin errors++; $display("FAIL b2b_rsp: valid=%b rdata=%h want 1 05060708", bus.o_rsp_valid, bus.o_rdata); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      drive_req(1'b0, 3'b010, 32'h0000_0030, 32'h0);
      @(negedge clk);
      idle_inputs();
      checks++; if (bus.o_mem_req !== 1'b1) begin errors++; $display("FAIL rm_busy: req=%b want 1", bus.o_mem_req); end
      #2 rst = 1'b0;
      #1;
      checks++; if (bus.o_mem_req !== 1'b0 || bus.o_req_ready !== 1'b1 || bus.o_stall !== 1'b0) begin errors++; $display("FAIL rm_abort: req=%b ready=%b stall=%b want 0 1 0", bus.o_mem_req, bus.o_req_ready, bus.o_stall); end
      @(negedge clk);
      rst = 1'b1;
      drive_req(1'b0, 3'b010, 32'h0000_0034, 32'h0);
      @(negedge clk);
      idle_inputs();
      checks++; if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 32'h0000_0034) begin errors++; $display("FAIL rm_next_req: req=%b addr=%h want 1 00000034", bus.o_mem_req, bus.o_mem_addr); end
      bus.i_mem_ack   = 1'b1;
      bus.i_mem_rdata = 32'h1122_3344;
      @(negedge clk);
      idle_inputs();
      checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_err !== 1'b0 || bus.o_rdata !== 32'h1122_3344) begin errors++; $display("FAIL rm_next_rsp: valid=%b err=%b rdata=%h want 1 0 11223344", bus.o_rsp_valid, bus.o_rsp_err, bus.o_rdata); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_lb_wait();
      test_load_vectors();
      test_stores();
      test_misaligned();
      test_timeout();
      test_ack_at_timeout();
      test_stray_ack();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
